xoodyak_out_serializer: RTL

- Downstream neighbour of xoodyak_build; consumes its 192-bit textout_r / textout_valid result stream.
- Buffers completed text blocks in a small FIFO and emits them as 32-bit words over a valid/ready interface toward the host bus.
- Decouples the one-shot core output from host backpressure and flags any block lost to overflow.

---
 rtl/xoodyak_out_serializer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/xoodyak_out_serializer.sv
// xoodyak_out_serializer
//   Buffers 192-bit text blocks from xoodyak_build in a small block FIFO and
//   emits each block as WORD_W-bit words, most-significant word first, over a
//   valid/ready handshake toward the host bus. A block arriving while the
//   FIFO is full is dropped and latches a sticky overflow flag.
//
//   Optional build macro: XOOD_OUT_PARITY_EN adds word_parity_o (XOR-reduce of
//   word_o, forced low while no word is valid).
//
// Ports
//   eph1           clock, rising edge
//   reset          asynchronous active-high reset
//   textout_r      text block from the core
//   textout_valid  one-cycle strobe qualifying textout_r
//   word_o         current output word
//   word_valid_o   word_o is valid
//   word_ready_i   host accepts word_o when valid and ready are both high
//   word_last_o    word_o is the final word of its block
//   overflow_o     sticky: at least one block was dropped
//   fifo_count_o   number of occupied block entries
//   word_parity_o  (XOOD_OUT_PARITY_EN only) even-parity bit for word_o
module xoodyak_out_serializer #(
  parameter int BLK_W  = 192,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       eph1,
  input  logic                       reset,
  input  logic [BLK_W-1:0]           textout_r,
  input  logic                       textout_valid,
  output logic [WORD_W-1:0]          word_o,
  output logic                       word_valid_o,
  input  logic                       word_ready_i,
  output logic                       word_last_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
`ifdef XOOD_OUT_PARITY_EN
  ,
  output logic                       word_parity_o
`endif
);

  localparam int WORDS = BLK_W / WORD_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [BLK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WC_W-1:0]  word_cnt;
  logic             overflow;

  logic             vld;
  logic             last_word;
  logic             hs;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             push_drop;

  // Word idx of a block, counting from the most-significant end.
  function automatic logic [WORD_W-1:0] sel_word(input logic [BLK_W-1:0] blk,
                                                 input logic [WC_W-1:0]  idx);
    logic [BLK_W-1:0] sh;
    sh = blk << (WORD_W * int'(idx));
    return sh[BLK_W-1 -: WORD_W];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign vld       = (state == SEND);
  assign last_word = (word_cnt == WC_W'(WORDS - 1));
  assign hs        = vld & word_ready_i;
  assign pop       = hs & last_word;
  assign full      = (count == CNT_W'(DEPTH));
  // A push into a full FIFO still fits when the head block leaves this cycle:
  // the freed slot is exactly the one the write pointer addresses.
  assign push_ok   = textout_valid & (~full | pop);
  assign push_drop = textout_valid & full & ~pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (push_ok) state_nxt = SEND;
      SEND: if (pop && !push_ok && count == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: pointers, occupancy, word index, sticky overflow
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push_ok) count <= count - CNT_W'(1);
      if (hs) word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
      if (push_drop) overflow <= 1'b1;
    end
  end

  // Block storage: data only, never observed until a push has filled it
  always_ff @(posedge eph1) begin
    if (push_ok) mem[wr_ptr] <= textout_r;
  end

  // Output word is gated so stale FIFO contents never reach the bus
  assign word_o       = vld ? sel_word(mem[rd_ptr], word_cnt) : '0;
  assign word_valid_o = vld;
  assign word_last_o  = vld & last_word;
  assign overflow_o   = overflow;
  assign fifo_count_o = count;

`ifdef XOOD_OUT_PARITY_EN
  assign word_parity_o = ^word_o;
`endif

endmodule
